// File: rtl/pc_jump_unit.sv
`default_nettype none
// ============================================================================
//  Module      : pc_jump_unit
//  Description : Hack CPU program-counter stage. Evaluates the C-instruction
//                jump field against the ALU flags, registers the next
//                instruction address, and freezes the CPU once the
//                end-of-program self-loop has executed twice in a row.
//  Revision    : 1.0 - initial release
// ============================================================================
module pc_jump_unit #(
    parameter int unsigned    WIDTH     = 16,
    parameter logic [WIDTH-1:0] RESET_VEC = '0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             en,
    input  logic             is_c,
    input  logic [2:0]       jbits,
    input  logic             zr,
    input  logic             ng,
    input  logic [WIDTH-1:0] a_in,
    output logic [WIDTH-1:0] pc_out,
    output logic             jump_taken,
    output logic             halted
);

    // RUN: normal flow; SPIN: one self-jump seen; HALTED: sticky until reset.
    typedef enum logic [1:0] {
        RUN    = 2'd0,
        SPIN   = 2'd1,
        HALTED = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] c_one = WIDTH'(1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_pc;
    logic             r_jump_taken;
    logic             w_take;
    logic             w_self;
    logic             w_halted;

    // Jump decision from j1/j2/j3 against lt/eq/gt; illegal zr=ng=1 uses the same formula.
    always_comb begin
        w_take = is_c & ((jbits[2] & ng) |
                         (jbits[1] & zr) |
                         (jbits[0] & ~ng & ~zr));
        w_self = w_take & (a_in == r_pc);
    end

    assign w_halted = (r_state == HALTED);

    // Self-loop detector: two consecutive enabled self-jumps lock into HALTED.
    always_comb begin
        w_state_nxt = r_state;
        if (en) begin
            case (r_state)
                RUN:     w_state_nxt = w_self ? SPIN : RUN;
                SPIN:    w_state_nxt = w_self ? HALTED : RUN;
                HALTED:  w_state_nxt = HALTED;
                default: w_state_nxt = RUN;
            endcase
        end
    end

    // State, PC and jump-flag registers; halt and stall both freeze the PC.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state      <= RUN;
            r_pc         <= RESET_VEC;
            r_jump_taken <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_jump_taken <= en & ~w_halted & w_take;
            if (en && !w_halted) begin
                r_pc <= w_take ? a_in : (r_pc + c_one);
            end
        end
    end

    assign pc_out     = r_pc;
    assign jump_taken = r_jump_taken;
    assign halted     = w_halted;

endmodule
`default_nettype wire

// File: tb/tb_pc_jump_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pc_jump_unit
//  Description : Directed-vector bench for pc_jump_unit. The driver pushes the
//                hand-computed post-edge outputs into a queue; the monitor pops
//                and compares one entry after every rising edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pc_jump_unit;

    localparam int unsigned WIDTH = 16;

    typedef struct packed {
        logic [WIDTH-1:0] pc;
        logic             jt;
        logic             h;
    } exp_t;

    logic             clock;
    logic             reset;
    logic             en;
    logic             is_c;
    logic [2:0]       jbits;
    logic             zr;
    logic             ng;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] pc_out;
    logic             jump_taken;
    logic             halted;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;
    int   vec_no = 0;

    pc_jump_unit #(
        .WIDTH     (WIDTH),
        .RESET_VEC (16'h0000)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .en         (en),
        .is_c       (is_c),
        .jbits      (jbits),
        .zr         (zr),
        .ng         (ng),
        .a_in       (a_in),
        .pc_out     (pc_out),
        .jump_taken (jump_taken),
        .halted     (halted)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Drive one cycle of inputs on the falling edge and queue what must follow the next rising edge.
    task automatic step(input logic r, input logic e, input logic c, input logic [2:0] j,
                        input logic z, input logic n, input logic [WIDTH-1:0] a,
                        input logic [WIDTH-1:0] epc, input logic ejt, input logic eh);
        exp_t x;
        @(negedge clock);
        reset = r; en = e; is_c = c; jbits = j; zr = z; ng = n; a_in = a;
        x.pc = epc; x.jt = ejt; x.h = eh;
        exp_q.push_back(x);
    endtask

    // Monitor: one output set per rising edge, compared against the queue head.
    initial begin
        exp_t e;
        int   idx;
        idx = 0;
        forever begin
            @(posedge clock);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                idx++;
                checks++;
                if (pc_out !== e.pc) begin
                    errors++;
                    $display("FAIL v%0d pc_out: got %h expected %h", idx, pc_out, e.pc);
                end
                checks++;
                if (jump_taken !== e.jt) begin
                    errors++;
                    $display("FAIL v%0d jump_taken: got %b expected %b", idx, jump_taken, e.jt);
                end
                checks++;
                if (halted !== e.h) begin
                    errors++;
                    $display("FAIL v%0d halted: got %b expected %b", idx, halted, e.h);
                end
            end
        end
    end

    initial begin
        int waited;
        reset = 1'b1; en = 1'b0; is_c = 1'b0; jbits = 3'b000; zr = 1'b0; ng = 1'b0; a_in = '0;

        //    rst en  c  jbits   zr ng a_in      -> pc        jt h
        step(1, 0, 0, 3'b000, 0, 0, 16'h0000,   16'h0000, 0, 0);
        // increment
        step(0, 1, 0, 3'b000, 0, 0, 16'h0000,   16'h0001, 0, 0);
        step(0, 1, 0, 3'b000, 0, 0, 16'h0000,   16'h0002, 0, 0);
        step(0, 1, 0, 3'b000, 0, 0, 16'h0000,   16'h0003, 0, 0);
        // unconditional jump, then flag drops on increment
        step(0, 1, 1, 3'b111, 0, 0, 16'h0005,   16'h0005, 1, 0);
        step(0, 1, 0, 3'b000, 0, 0, 16'h0000,   16'h0006, 0, 0);
        // conditional jumps
        step(0, 1, 1, 3'b001, 0, 1, 16'h0040,   16'h0007, 0, 0);
        step(0, 1, 1, 3'b001, 0, 0, 16'h0040,   16'h0040, 1, 0);
        step(0, 1, 1, 3'b010, 1, 0, 16'h0050,   16'h0050, 1, 0);
        step(0, 1, 0, 3'b111, 0, 0, 16'h0060,   16'h0051, 0, 0);
        step(0, 1, 1, 3'b100, 0, 1, 16'h0070,   16'h0070, 1, 0);
        step(0, 1, 1, 3'b000, 1, 1, 16'h0080,   16'h0071, 0, 0);
        step(0, 1, 1, 3'b011, 1, 1, 16'h0090,   16'h0090, 1, 0);
        step(0, 1, 1, 3'b001, 1, 1, 16'h00A0,   16'h0091, 0, 0);
        // wrap
        step(0, 1, 1, 3'b111, 0, 0, 16'hFFFF,   16'hFFFF, 1, 0);
        step(0, 1, 0, 3'b000, 0, 0, 16'h0000,   16'h0000, 0, 0);
        step(0, 1, 1, 3'b111, 0, 0, 16'hFFFB,   16'hFFFB, 1, 0);
        step(0, 1, 0, 3'b000, 0, 0, 16'h0000,   16'hFFFC, 0, 0);
        // single self-jump then increment returns to RUN
        step(0, 1, 1, 3'b111, 0, 0, 16'hFFFC,   16'hFFFC, 1, 0);
        step(0, 1, 0, 3'b000, 0, 0, 16'h0000,   16'hFFFD, 0, 0);
        step(0, 1, 1, 3'b111, 0, 0, 16'hFFFD,   16'hFFFD, 1, 0);
        // stall with a pending jump between two self-jumps
        step(0, 0, 1, 3'b111, 0, 0, 16'h0020,   16'hFFFD, 0, 0);
        step(0, 1, 1, 3'b111, 0, 0, 16'hFFFD,   16'hFFFD, 1, 1);
        // halted ignores jumps and increments
        step(0, 1, 1, 3'b111, 0, 0, 16'h0030,   16'hFFFD, 0, 1);
        step(0, 1, 0, 3'b000, 0, 0, 16'h0000,   16'hFFFD, 0, 1);
        // reset together with a taken jump
        step(1, 1, 1, 3'b111, 0, 0, 16'h0033,   16'h0000, 0, 0);
        // halt at 0x0010
        step(0, 1, 1, 3'b111, 0, 0, 16'h0010,   16'h0010, 1, 0);
        step(0, 1, 1, 3'b111, 0, 0, 16'h0010,   16'h0010, 1, 0);
        step(0, 1, 1, 3'b111, 0, 0, 16'h0010,   16'h0010, 1, 1);
        step(0, 1, 1, 3'b111, 0, 0, 16'h0044,   16'h0010, 0, 1);
        step(0, 0, 0, 3'b000, 0, 0, 16'h0000,   16'h0010, 0, 1);
        // reset exits halt
        step(1, 1, 0, 3'b000, 0, 0, 16'h0000,   16'h0000, 0, 0);
        step(0, 1, 0, 3'b000, 0, 0, 16'h0000,   16'h0001, 0, 0);

        waited = 0;
        while (exp_q.size() > 0 && waited < 10) begin
            @(posedge clock);
            waited++;
        end
        #2;
        if (exp_q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
